// File: rtl/srlatch_bank_ctrl_pkg.sv
// Shared types for the SR latch bank controller:
// FSM state encodings, op encodings and a pointer-width helper.
package srlatch_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/srlatch_bank_ctrl_rr.sv
// Round-robin grant: first valid requester at or after rr_ptr,
// wrapping to the lowest index below it.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && i >= int'(rr_ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/srlatch_bank_ctrl.sv
// Arbitrates set/clear requests onto an SR latch bank as registered pulses.
// Define SRLATCH_QCHECK_EN to add the q read-back CHECK state and chk_err.
module srlatch_bank_ctrl
  import srlatch_bank_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NLATCH  = 4,
  parameter int IDX_W   = 2,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*IDX_W-1:0]   req_idx,
  output logic [NREQ-1:0]         req_ready,
  output logic [NLATCH-1:0]       latch_s,
  output logic [NLATCH-1:0]       latch_r,
  input  logic [NLATCH-1:0]       latch_q,
  output logic                    busy,
  output logic                    err_idx
`ifdef SRLATCH_QCHECK_EN
  ,
  output logic                    chk_err
`endif
);

  localparam int PTR_W   = ptr_w(NREQ);
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W:0] NL = (IDX_W+1)'(NLATCH);
`ifdef SRLATCH_QCHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  state_t              state, nxt;
  logic [CNT_W-1:0]    cnt;
  logic [PTR_W-1:0]    rr_ptr, rr_nxt;
  logic                op_q, gop;
  logic [IDX_W-1:0]    idx_q, gidx;
  logic [NREQ-1:0]     grant, ready_d;
  logic [NLATCH-1:0]   dec, s_d, r_d;
  logic                in_range, accept;
  logic                pulse_done, gap_done;
  logic                busy_d, err_d;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant)
  );

  always_comb begin
    gop    = 1'b0;
    gidx   = '0;
    rr_nxt = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gop    = req_op[i];
        gidx   = req_idx[i*IDX_W +: IDX_W];
        rr_nxt = PTR_W'((i + 1) % NREQ);
      end
    end
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < NLATCH; i++)
      dec[i] = (idx_q == IDX_W'(i));
  end

  assign in_range   = {1'b0, idx_q} < NL;
  assign accept     = (state == ST_IDLE) && |(req_ready & req_valid);
  assign pulse_done = (cnt == CNT_W'(PULSE_W - 1));
  assign gap_done   = (cnt == CNT_W'(GAP_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) nxt = ST_PULSE;
      ST_PULSE: if (pulse_done) nxt = ST_GAP;
      ST_GAP:   if (gap_done) nxt = CHK_EN ? ST_CHECK : ST_IDLE;
      ST_CHECK: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Ready is issued on the edge entering IDLE so a waiting requester
  // is granted in the very first IDLE cycle.
  always_comb begin
    ready_d = (nxt == ST_IDLE) ? grant : '0;
    s_d     = '0;
    r_d     = '0;
    if (nxt == ST_PULSE && in_range) begin
      if (op_q == OP_SET) s_d = dec;
      if (op_q == OP_RST) r_d = dec;
    end
    busy_d = (nxt != ST_IDLE);
    err_d  = accept && !in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      latch_s   <= '0;
      latch_r   <= '0;
      busy      <= 1'b0;
      err_idx   <= 1'b0;
      cnt       <= '0;
      rr_ptr    <= '0;
      op_q      <= 1'b0;
      idx_q     <= '0;
    end else begin
      req_ready <= ready_d;
      latch_s   <= s_d;
      latch_r   <= r_d;
      busy      <= busy_d;
      err_idx   <= err_d;
      if (nxt != state)         cnt <= '0;
      else if (state != ST_IDLE) cnt <= cnt + 1'b1;
      if (|ready_d) begin
        op_q   <= gop;
        idx_q  <= gidx;
        rr_ptr <= rr_nxt;
      end
    end
  end

`ifdef SRLATCH_QCHECK_EN
  logic chk_d;

  // q is sampled in the last GAP cycle so chk_err lands inside CHECK.
  assign chk_d = (state == ST_GAP) && (nxt == ST_CHECK) && in_range &&
                 ((|(latch_q & dec)) != op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err <= 1'b0;
    else        chk_err <= chk_d;
  end
`else
  logic unused_q;
  assign unused_q = ^latch_q;
`endif

endmodule

// File: tb/tb_srlatch_bank_ctrl.sv
// Randomized bench for srlatch_bank_ctrl against a grant-schedule model
// plus directed set, contention, conflict, bad index and mid-pulse reset.
module tb_srlatch_bank_ctrl;

  localparam int NREQ = 2;
  localparam int NL   = 3;
  localparam int IW   = 2;
  localparam int PW   = 2;
  localparam int GW   = 1;
`ifdef SRLATCH_QCHECK_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct {
    bit op;
    int idx;
  } rq_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid, req_op, req_ready;
  logic [NREQ*IW-1:0] req_idx;
  logic [NL-1:0]     latch_s, latch_r, latch_q;
  logic [NL-1:0]     bank;
  logic              busy, err_idx;
`ifdef SRLATCH_QCHECK_EN
  logic              chk_err;
`endif
  bit                force_q0;

  rq_t           rq [NREQ][$];
  int            t, free_at, rr, lt, lreq, lidx;
  bit            lop;
  bit [NREQ-1:0] pv;
  bit [NL-1:0]   exp_q;
  int            n_cmp, n_bad;

  always #5 clk = ~clk;

  assign latch_q = force_q0 ? (bank & ~NL'(1)) : bank;

  srlatch_bank_ctrl #(
    .NREQ    (NREQ),
    .NLATCH  (NL),
    .IDX_W   (IW),
    .PULSE_W (PW),
    .GAP_W   (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .latch_s   (latch_s),
    .latch_r   (latch_r),
    .latch_q   (latch_q),
    .busy      (busy),
    .err_idx   (err_idx)
`ifdef SRLATCH_QCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_op[i]    = rq[i][0].op;
        req_idx[i*IW +: IW] = IW'(rq[i][0].idx);
      end else begin
        req_valid[i] = 1'b0;
        req_op[i]    = 1'b0;
        req_idx[i*IW +: IW] = '0;
      end
    end
  endtask

  task automatic cycle();
    int d;
    int g;
    bit [NL-1:0] es, er, pres;
    @(negedge clk);
    t++;
    if (t >= free_at && pv != 0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pv[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      lt      = t;
      lreq    = g;
      lop     = req_op[g];
      lidx    = int'(req_idx[g*IW +: IW]);
      rr      = (g + 1) % NREQ;
      free_at = t + 1 + PW + GW + CK;
      if (lidx < NL) exp_q[lidx] = lop;
    end
    d  = t - lt;
    es = '0;
    er = '0;
    if (d >= 1 && d <= PW && lidx < NL) begin
      if (lop) es[lidx] = 1'b1;
      else     er[lidx] = 1'b1;
    end
    check("req_ready", int'(req_ready), (d == 0) ? (1 << lreq) : 0);
    check("latch_s", int'(latch_s), int'(es));
    check("latch_r", int'(latch_r), int'(er));
    check("sr_overlap", int'(|(latch_s & latch_r)), 0);
    check("busy", int'(busy), int'(d >= 1 && d <= PW + GW + CK));
    check("err_idx", int'(err_idx), int'(d == 1 && lidx >= NL));
`ifdef SRLATCH_QCHECK_EN
    pres = force_q0 ? (exp_q & ~NL'(1)) : exp_q;
    check("chk_err", int'(chk_err),
          int'(d == PW + GW + 1 && lidx < NL && pres[lidx] != lop));
`endif
    for (int i = 0; i < NL; i++) begin
      if (latch_s[i])      bank[i] = 1'b1;
      else if (latch_r[i]) bank[i] = 1'b0;
    end
    if (d >= 1) check("bank_q", int'(bank), int'(exp_q));
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    pv = req_valid;
    @(posedge clk);
    #1 drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_s", int'(latch_s), 0);
    check("rst_r", int'(latch_r), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_idx), 0);
`ifdef SRLATCH_QCHECK_EN
    check("rst_chk", int'(chk_err), 0);
`endif
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    drive();
    pv      = '0;
    lt      = -1000;
    rr      = 0;
    free_at = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (n < max &&
           (rq[0].size() > 0 || rq[1].size() > 0 || t - lt <= PW + GW + CK + 1)) begin
      cycle();
      n++;
    end
    if (n >= max) check("timeout", 1, 0);
  endtask

  initial begin
    int n;
    bank = '0;
    exp_q = '0;
    force_q0 = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    t = 0;
    lreq = 0;
    lidx = 0;
    lop = 1'b0;
    drive();
    do_reset();

    rq[0].push_back('{1'b1, 2});
    run_idle(40);

    do_reset();
    rq[0].push_back('{1'b1, 0});
    rq[0].push_back('{1'b0, 0});
    rq[1].push_back('{1'b1, 1});
    run_idle(60);

    rq[0].push_back('{1'b0, 2});
    n = 0;
    cycle();
    while (n < 40 && t + 1 != lt + 2) begin
      cycle();
      n++;
    end
    if (n >= 40) check("timeout_mid", 1, 0);
    #2;
    check("pulse_before_rst", int'(latch_r), 4);
    do_reset();
    check("bank_after_rst", int'(bank[2]), 0);

    rq[0].push_back('{1'b1, 1});
    rq[1].push_back('{1'b0, 1});
    run_idle(60);
    check("conflict_q1", int'(bank[1]), 0);

    rq[1].push_back('{1'b1, 3});
    run_idle(40);

`ifdef SRLATCH_QCHECK_EN
    force_q0 = 1'b1;
    rq[0].push_back('{1'b1, 0});
    run_idle(40);
    force_q0 = 1'b0;
`endif

    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (rq[i].size() == 0 && $urandom_range(0, 2) == 0)
          rq[i].push_back('{1'($urandom_range(0, 1)), int'($urandom_range(0, 3))});
      cycle();
    end
    run_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
